scoreboard: RTL and testbench

SCOREBOARD -- requirements
Module: scoreboard

---
 rtl/scoreboard.sv | 133 +++++++++++++
 tb/tb_scoreboard.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/scoreboard.sv
// Register scoreboard: per-register pending-write counters
// with hazard lookup, write-first bypass and sticky error.
module scoreboard #(
  parameter int NREG = 32,
  parameter int CW   = 2
) (
  input  logic            clk,
  input  logic            reset_x,
  input  logic [4:0]      Di_rs1,
  input  logic [4:0]      Di_rs2,
  input  logic [4:0]      Di_rd,
  input  logic            Di_regWrite,
  input  logic            Di_issue,
  input  logic [4:0]      Ei_rd,
  input  logic            Ei_regWrite,
  input  logic            Ei_cancel,
  input  logic [4:0]      Wi_rd,
  input  logic            Wi_regWrite,
  output logic            Do_rs1Busy,
  output logic            Do_rs2Busy,
  output logic            Do_stall,
  output logic [NREG-1:0] Ao_busyMap,
  output logic            Ao_error
);

  localparam int NW   = CW + 2;
  localparam int CMAX = (1 << CW) - 1;
  localparam logic signed [NW-1:0] CMAX_S = NW'(CMAX);

  logic [CW-1:0]   cnt    [NREG];
  logic [CW-1:0]   cnt_nx [NREG];
  logic [NREG-1:0] ovf;
  logic [NREG-1:0] inc_v;
  logic [NREG-1:0] canc_v;
  logic [NREG-1:0] ret_v;
  logic            inc;
  logic            canc;
  logic            ret;
  logic [CW-1:0]   c1;
  logic [CW-1:0]   c2;
  logic            byp1;
  logic            byp2;

  assign inc  = Di_issue & Di_regWrite
              & (Di_rd != 5'd0);
  assign canc = Ei_cancel & Ei_regWrite
              & (Ei_rd != 5'd0);
  assign ret  = Wi_regWrite
              & (Wi_rd != 5'd0);

  // Decode the three events into per-register strobes.
  always_comb begin
    inc_v  = '0;
    canc_v = '0;
    ret_v  = '0;
    if (inc && int'(Di_rd) < NREG)
      inc_v[Di_rd] = 1'b1;
    if (canc && int'(Ei_rd) < NREG)
      canc_v[Ei_rd] = 1'b1;
    if (ret && int'(Wi_rd) < NREG)
      ret_v[Wi_rd] = 1'b1;
  end

  // Net update per register with saturation and clamping.
  always_comb begin
    logic signed [NW-1:0] sum;
    sum = '0;
    ovf = '0;
    for (int r = 0; r < NREG; r++) begin
      cnt_nx[r] = '0;
      if (r != 0) begin
        sum = NW'(cnt[r])
            + NW'(inc_v[r])
            - NW'(canc_v[r])
            - NW'(ret_v[r]);
        unique case (1'b1)
          (sum < 0): begin
            cnt_nx[r] = '0;
            ovf[r]    = 1'b1;
          end
          (sum > CMAX_S): begin
            cnt_nx[r] = CW'(CMAX);
            ovf[r]    = 1'b1;
          end
          default: begin
            cnt_nx[r] = sum[CW-1:0];
          end
        endcase
      end
    end
  end

  // Counter state and sticky error; reset discards everything.
  always_ff @(posedge clk or posedge reset_x) begin
    if (reset_x) begin
      for (int r = 0; r < NREG; r++)
        cnt[r] <= '0;
      Ao_error <= 1'b0;
    end else begin
      cnt <= cnt_nx;
      if (|ovf)
        Ao_error <= 1'b1;
    end
  end

  // Busy map reflects registered counts only.
  always_comb begin
    Ao_busyMap = '0;
    for (int r = 1; r < NREG; r++)
      Ao_busyMap[r] = (cnt[r] != '0);
  end

  assign c1 = (int'(Di_rs1) < NREG)
            ? cnt[Di_rs1] : '0;
  assign c2 = (int'(Di_rs2) < NREG)
            ? cnt[Di_rs2] : '0;

  // A last pending write retiring now is forwarded
  // by the register file, so it does not block.
  assign byp1 = ret & (Wi_rd == Di_rs1)
              & (c1 == CW'(1));
  assign byp2 = ret & (Wi_rd == Di_rs2)
              & (c2 == CW'(1));

  assign Do_rs1Busy = ~reset_x
                    & (Di_rs1 != 5'd0)
                    & (c1 != '0) & ~byp1;
  assign Do_rs2Busy = ~reset_x
                    & (Di_rs2 != 5'd0)
                    & (c2 != '0) & ~byp2;
  assign Do_stall   = Do_rs1Busy | Do_rs2Busy;

endmodule

// File: tb/tb_scoreboard.sv
// Randomized + directed bench for scoreboard with
// a queued expected-response monitor.
module tb_scoreboard;

  logic        clk = 1'b0;
  logic        reset_x = 1'b1;
  logic [4:0]  Di_rs1 = '0, Di_rs2 = '0, Di_rd = '0;
  logic        Di_regWrite = 1'b0, Di_issue = 1'b0;
  logic [4:0]  Ei_rd = '0;
  logic        Ei_regWrite = 1'b0, Ei_cancel = 1'b0;
  logic [4:0]  Wi_rd = '0;
  logic        Wi_regWrite = 1'b0;
  logic        Do_rs1Busy, Do_rs2Busy, Do_stall;
  logic [31:0] Ao_busyMap;
  logic        Ao_error;

  scoreboard #(.NREG(32), .CW(2)) dut (
    .clk(clk), .reset_x(reset_x),
    .Di_rs1(Di_rs1), .Di_rs2(Di_rs2), .Di_rd(Di_rd),
    .Di_regWrite(Di_regWrite), .Di_issue(Di_issue),
    .Ei_rd(Ei_rd), .Ei_regWrite(Ei_regWrite),
    .Ei_cancel(Ei_cancel),
    .Wi_rd(Wi_rd), .Wi_regWrite(Wi_regWrite),
    .Do_rs1Busy(Do_rs1Busy), .Do_rs2Busy(Do_rs2Busy),
    .Do_stall(Do_stall),
    .Ao_busyMap(Ao_busyMap), .Ao_error(Ao_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        b1;
    logic        b2;
    logic        st;
    logic [31:0] map;
    logic        err;
  } exp_t;

  exp_t q[$];
  exp_t em;
  int   asserts = 0;
  int   fails = 0;
  int   mcnt[32];
  bit   merr = 1'b0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    asserts++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h @%0t",
               name, act, exp, $time);
    end
  endtask

  // Monitor: one expected response per driven cycle.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      em = q.pop_front();
      chk("rs1Busy", 32'(Do_rs1Busy), 32'(em.b1));
      chk("rs2Busy", 32'(Do_rs2Busy), 32'(em.b2));
      chk("stall",   32'(Do_stall),   32'(em.st));
      chk("busyMap", Ao_busyMap,      em.map);
      chk("error",   32'(Ao_error),   32'(em.err));
    end
  end

  function automatic bit mbusy(input logic [4:0] rs,
                               input bit ret,
                               input logic [4:0] wrd);
    if (rs == 5'd0 || mcnt[rs] == 0) return 1'b0;
    if (mcnt[rs] == 1 && ret && wrd == rs) return 1'b0;
    return 1'b1;
  endfunction

  task automatic mclear();
    for (int r = 0; r < 32; r++) mcnt[r] = 0;
    merr = 1'b0;
  endtask

  task automatic step(input logic [4:0] rs1, rs2, rd,
                      input bit rw, iss,
                      input logic [4:0] erd,
                      input bit erw, ecan,
                      input logic [4:0] wrd,
                      input bit wrw);
    exp_t e;
    bit   inc, canc, ret;
    int   n;
    @(posedge clk);
    #1;
    Di_rs1 = rs1; Di_rs2 = rs2; Di_rd = rd;
    Di_regWrite = rw; Di_issue = iss;
    Ei_rd = erd; Ei_regWrite = erw; Ei_cancel = ecan;
    Wi_rd = wrd; Wi_regWrite = wrw;
    inc  = iss && rw && rd != 0;
    canc = ecan && erw && erd != 0;
    ret  = wrw && wrd != 0;
    e.b1  = mbusy(rs1, ret, wrd);
    e.b2  = mbusy(rs2, ret, wrd);
    e.st  = e.b1 | e.b2;
    e.map = '0;
    for (int r = 1; r < 32; r++) e.map[r] = (mcnt[r] != 0);
    e.err = merr;
    q.push_back(e);
    for (int r = 1; r < 32; r++) begin
      n = mcnt[r] + int'(inc && rd == r)
                  - int'(canc && erd == r)
                  - int'(ret && wrd == r);
      if (n > 3) begin n = 3; merr = 1'b1; end
      if (n < 0) begin n = 0; merr = 1'b1; end
      mcnt[r] = n;
    end
  endtask

  task automatic idle(input logic [4:0] rs1, rs2);
    step(rs1, rs2, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic issue(input logic [4:0] rd);
    step(0, 0, rd, 1, 1, 0, 0, 0, 0, 0);
  endtask

  task automatic retire(input logic [4:0] rs1, rs2, wrd);
    step(rs1, rs2, 0, 0, 0, 0, 0, 0, wrd, 1);
  endtask

  // Reset pulse between clock edges, checked immediately.
  task automatic rst_pulse(input logic [4:0] rs);
    @(posedge clk);
    #1;
    Di_rs1 = rs; Di_rs2 = rs; Di_rd = '0;
    Di_regWrite = 0; Di_issue = 0;
    Ei_regWrite = 0; Ei_cancel = 0; Wi_regWrite = 0;
    #1 reset_x = 1'b1;
    #1;
    chk("rst_map",   Ao_busyMap,       32'd0);
    chk("rst_err",   32'(Ao_error),    32'd0);
    chk("rst_stall", 32'(Do_stall),    32'd0);
    chk("rst_rs1",   32'(Do_rs1Busy),  32'd0);
    #1 reset_x = 1'b0;
    mclear();
  endtask

  initial begin
    mclear();
    Di_rs1 = 5'd5; Di_rs2 = 5'd7;
    #3;
    chk("init_map",   Ao_busyMap,    32'd0);
    chk("init_err",   32'(Ao_error), 32'd0);
    chk("init_stall", 32'(Do_stall), 32'd0);
    @(negedge clk);
    reset_x = 1'b0;

    // rd=5 hazard until retire, bypass in retire cycle
    issue(5);
    idle(5, 0);
    idle(5, 0);
    retire(5, 0, 5);
    idle(5, 0);

    // two writes to 7 in flight
    issue(7);
    issue(7);
    retire(0, 7, 7);
    idle(0, 7);
    retire(0, 7, 7);
    idle(0, 7);

    // same-cycle issue and cancel on 3, then later cancel
    step(3, 0, 3, 1, 1, 3, 1, 1, 0, 0);
    idle(3, 0);
    issue(3);
    step(3, 0, 0, 0, 0, 3, 1, 1, 0, 0);
    idle(3, 0);

    // read-and-write of same reg in decode
    step(4, 4, 4, 1, 1, 0, 0, 0, 0, 0);
    step(4, 0, 4, 1, 1, 0, 0, 0, 0, 0);
    retire(4, 0, 4);
    retire(4, 0, 4);
    idle(4, 0);

    // register zero is never tracked
    step(0, 0, 0, 1, 1, 0, 1, 1, 0, 1);
    idle(0, 0);

    // saturation, then underflow; error is sticky
    issue(9);
    issue(9);
    issue(9);
    issue(9);
    idle(9, 9);
    retire(9, 0, 9);
    retire(9, 0, 9);
    retire(9, 0, 9);
    retire(9, 0, 9);
    idle(9, 0);

    // async reset mid-operation, then normal events
    issue(6);
    issue(11);
    idle(6, 11);
    rst_pulse(6);
    issue(6);
    idle(6, 0);
    retire(6, 0, 6);
    idle(6, 0);

    // randomized traffic with occasional reset pulses
    for (int i = 0; i < 400; i++) begin
      if (i % 100 == 99)
        rst_pulse(5'($urandom_range(1, 7)));
      else
        step(5'($urandom_range(0, 7)),
             5'($urandom_range(0, 7)),
             5'($urandom_range(0, 7)),
             ($urandom_range(0, 99) < 80),
             ($urandom_range(0, 99) < 45),
             5'($urandom_range(0, 7)),
             ($urandom_range(0, 99) < 80),
             ($urandom_range(0, 99) < 15),
             5'($urandom_range(0, 7)),
             ($urandom_range(0, 99) < 55));
    end

    idle(0, 0);
    @(posedge clk);
    @(posedge clk);
    chk("queue_drain", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             asserts, fails);
    $finish;
  end

endmodule
